// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, iterator FSM states and op-class helpers for alu_muldiv.
package alu_muldiv_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] alu_sll   = 6'h00;
    localparam logic [OP_W-1:0] alu_srl   = 6'h02;
    localparam logic [OP_W-1:0] alu_sra   = 6'h03;
    localparam logic [OP_W-1:0] alu_sllv  = 6'h04;
    localparam logic [OP_W-1:0] alu_srlv  = 6'h06;
    localparam logic [OP_W-1:0] alu_srav  = 6'h07;
    localparam logic [OP_W-1:0] alu_lui   = 6'h0F;
    localparam logic [OP_W-1:0] alu_mfhi  = 6'h10;
    localparam logic [OP_W-1:0] alu_mthi  = 6'h11;
    localparam logic [OP_W-1:0] alu_mflo  = 6'h12;
    localparam logic [OP_W-1:0] alu_mtlo  = 6'h13;
    localparam logic [OP_W-1:0] alu_mult  = 6'h18;
    localparam logic [OP_W-1:0] alu_multu = 6'h19;
    localparam logic [OP_W-1:0] alu_div   = 6'h1A;
    localparam logic [OP_W-1:0] alu_divu  = 6'h1B;
    localparam logic [OP_W-1:0] alu_add   = 6'h20;
    localparam logic [OP_W-1:0] alu_addu  = 6'h21;
    localparam logic [OP_W-1:0] alu_sub   = 6'h22;
    localparam logic [OP_W-1:0] alu_subu  = 6'h23;
    localparam logic [OP_W-1:0] alu_and   = 6'h24;
    localparam logic [OP_W-1:0] alu_or    = 6'h25;
    localparam logic [OP_W-1:0] alu_xor   = 6'h26;
    localparam logic [OP_W-1:0] alu_nor   = 6'h27;
    localparam logic [OP_W-1:0] alu_slt   = 6'h2A;
    localparam logic [OP_W-1:0] alu_sltu  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == alu_mult) || (op == alu_multu);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == alu_div) || (op == alu_divu);
    endfunction

    function automatic logic is_signed_md(input logic [OP_W-1:0] op);
        return (op == alu_mult) || (op == alu_div);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// EX-stage ALU bus: operands/op/handshake from the pipeline, result, flags and HI/LO back.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [5:0]       op;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] y;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, shamt, op, start, flush,
        input  y, overflow, zero, busy, done, hi, lo
    );

    modport slave (
        input  a, b, shamt, op, start, flush,
        output y, overflow, zero, busy, done, hi, lo
    );

endinterface

// File: rtl/alu_muldiv_muldiv_iter.sv
// Iterative multiply/divide unit: one bit per cycle on magnitudes, sign fixed on the last step,
// results land in the architectural HI/LO registers.
module muldiv_iter
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       op,
    input  logic             start,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    md_state_t        state, state_next;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc, acc_step, prod_fix;
    logic [WIDTH-1:0] opb, mag_a, mag_b, rem_sub, quo_fix, rem_fix;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic             neg_hi, neg_lo, sgn, sa, sb, borrow;
    logic             can_issue, ld_mul, ld_div, last;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        can_issue  = (state == ST_IDLE) || (state == ST_DONE);
        ld_mul     = can_issue && start && is_mul_op(op);
        ld_div     = can_issue && start && is_div_op(op);
        last       = (cnt == CW'(WIDTH - 1));
        busy       = (state == ST_MUL) || (state == ST_DIV);
        done       = (state == ST_DONE);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (ld_mul)      state_next = ST_MUL;
                else if (ld_div) state_next = ST_DIV;
                else             state_next = ST_IDLE;
            end
            ST_MUL, ST_DIV: begin
                if (flush)     state_next = ST_IDLE;
                else if (last) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand magnitudes at issue time
    assign sgn   = is_signed_md(op);
    assign sa    = sgn & a[WIDTH-1];
    assign sb    = sgn & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // One shift-add or restoring-subtract step; acc = {hi_part, lo_part}
    assign mul_sum = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign div_sh  = {acc[PW-1:WIDTH], acc[WIDTH-1]};
    assign borrow  = div_sh < {1'b0, opb};
    assign rem_sub = div_sh[WIDTH-1:0] - opb;

    always_comb begin
        acc_step = acc;
        if (state == ST_MUL)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (borrow)
            acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end

    assign prod_fix = neg_lo ? -acc_step : acc_step;
    assign quo_fix  = neg_lo ? -acc_step[WIDTH-1:0]  : acc_step[WIDTH-1:0];
    assign rem_fix  = neg_hi ? -acc_step[PW-1:WIDTH] : acc_step[PW-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (ld_mul) begin
                cnt    <= '0;
                acc    <= {WIDTH'(0), mag_b};
                opb    <= mag_a;
                neg_lo <= sa ^ sb;
                neg_hi <= sa ^ sb;
            end else if (ld_div) begin
                cnt    <= '0;
                acc    <= {WIDTH'(0), mag_a};
                opb    <= mag_b;
                // Divide by zero keeps an all-ones quotient and hands back the dividend
                neg_lo <= (sa ^ sb) && (b != '0);
                neg_hi <= sa;
            end else if (busy && !flush) begin
                cnt <= cnt + CW'(1);
                acc <= acc_step;
                if (last) begin
                    if (state == ST_MUL) begin
                        hi <= prod_fix[PW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
            end else if (busy) begin
                cnt <= '0;
            end
            if (can_issue && start && (op == alu_mthi)) hi <= a;
            if (can_issue && start && (op == alu_mtlo)) lo <= a;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle op mux and flags around the iterative mul/div unit.
// Define ALU_OVF_DETECT_EN to enable signed-overflow detection on alu_add/alu_sub.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_muldiv_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum, diff, y, hi, lo;
    logic             busy, done, ovf;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .a     (bus.a),
        .b     (bus.b),
        .op    (bus.op),
        .start (bus.start),
        .flush (bus.flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    // Result mux; unknown op codes read as zero
    always_comb begin
        y = '0;
        case (bus.op)
            alu_add, alu_addu: y = sum;
            alu_sub, alu_subu: y = diff;
            alu_slt:  y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            alu_sltu: y = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            alu_and:  y = bus.a & bus.b;
            alu_or:   y = bus.a | bus.b;
            alu_xor:  y = bus.a ^ bus.b;
            alu_nor:  y = ~(bus.a | bus.b);
            alu_sll:  y = bus.b << bus.shamt;
            alu_srl:  y = bus.b >> bus.shamt;
            alu_sra:  y = $unsigned($signed(bus.b) >>> bus.shamt);
            alu_sllv: y = bus.b << bus.a[SHW-1:0];
            alu_srlv: y = bus.b >> bus.a[SHW-1:0];
            alu_srav: y = $unsigned($signed(bus.b) >>> bus.a[SHW-1:0]);
            alu_lui:  y = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            alu_mfhi: y = hi;
            alu_mflo: y = lo;
            default:  y = '0;
        endcase
    end

`ifdef ALU_OVF_DETECT_EN
    always_comb begin
        ovf = 1'b0;
        if (bus.op == alu_add)
            ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        else if (bus.op == alu_sub)
            ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    end
`else
    assign ovf = 1'b0;
`endif

    assign bus.y        = y;
    assign bus.zero     = (y == '0);
    assign bus.overflow = ovf;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.hi       = hi;
    assign bus.lo       = lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: vector table for single-cycle ops, scoreboard for mul/div.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int unsigned W = 32;
`ifdef ALU_OVF_DETECT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
    } md_vec_t;

    typedef struct {
        string       name;
        logic [63:0] hilo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    logic [31:0] prev_hi, prev_lo;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q, r;
        case (op)
            alu_mult: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 64'(p);
            end
            alu_multu: return {32'h0, a} * {32'h0, b};
            alu_div: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            alu_divu: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Drive a start strobe now; it is sampled at the next rising edge
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) cyc++;
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check({e.name, "_hilo"}, {bus.hi, bus.lo}, e.hilo);
        prev_hi = e.hilo[63:32];
        prev_lo = e.hilo[31:0];
    endtask

    task automatic run_md(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int cyc;
        bit ok;
        sb_q.push_back('{name, exp});
        issue(op, a, b);
        wait_done(cyc, ok);
        check({name, "_done_seen"}, 64'(ok), 64'd1);
        check({name, "_busy_cycles"}, 64'(cyc), 64'd32);
        pop_compare();
        @(negedge clk);
        check({name, "_done_pulse"}, {62'h0, bus.done, bus.busy}, 64'h0);
    endtask

    initial begin
        vec_t    vecs[$];
        md_vec_t mds[$];
        int      cyc;
        bit      ok;
        bit      seen;
        logic [5:0]  rop;
        logic [31:0] ra, rb;

        vecs.push_back('{"add_ovf",   alu_add,  32'h7FFF_FFFF, 32'h1,          5'd0,  32'h8000_0000, OVF_ON});
        vecs.push_back('{"addu_ovf",  alu_addu, 32'h7FFF_FFFF, 32'h1,          5'd0,  32'h8000_0000, 1'b0});
        vecs.push_back('{"add_zero",  alu_add,  32'h5,         32'hFFFF_FFFB,  5'd0,  32'h0,         1'b0});
        vecs.push_back('{"sub_ovf",   alu_sub,  32'h8000_0000, 32'h1,          5'd0,  32'h7FFF_FFFF, OVF_ON});
        vecs.push_back('{"subu",      alu_subu, 32'h5,         32'h7,          5'd0,  32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"slt",       alu_slt,  32'hFFFF_FFFF, 32'h1,          5'd0,  32'h1,         1'b0});
        vecs.push_back('{"sltu",      alu_sltu, 32'hFFFF_FFFF, 32'h1,          5'd0,  32'h0,         1'b0});
        vecs.push_back('{"and",       alu_and,  32'hF0F0,      32'hFF00,       5'd0,  32'hF000,      1'b0});
        vecs.push_back('{"or",        alu_or,   32'hF0F0,      32'hFF00,       5'd0,  32'hFFF0,      1'b0});
        vecs.push_back('{"xor",       alu_xor,  32'hF0F0,      32'hFF00,       5'd0,  32'h0FF0,      1'b0});
        vecs.push_back('{"nor",       alu_nor,  32'h0,         32'h0,          5'd0,  32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"sll",       alu_sll,  32'h0,         32'h1,          5'd31, 32'h8000_0000, 1'b0});
        vecs.push_back('{"srl",       alu_srl,  32'h0,         32'h8000_0000,  5'd4,  32'h0800_0000, 1'b0});
        vecs.push_back('{"sra",       alu_sra,  32'h0,         32'h8000_0000,  5'd4,  32'hF800_0000, 1'b0});
        vecs.push_back('{"sllv",      alu_sllv, 32'h24,        32'h1,          5'd0,  32'h10,        1'b0});
        vecs.push_back('{"srlv",      alu_srlv, 32'h21,        32'h8000_0000,  5'd0,  32'h4000_0000, 1'b0});
        vecs.push_back('{"srav",      alu_srav, 32'h4,         32'h8000_0000,  5'd9,  32'hF800_0000, 1'b0});
        vecs.push_back('{"lui",       alu_lui,  32'h0,         32'hABCD_1234,  5'd0,  32'h1234_0000, 1'b0});
        vecs.push_back('{"unknown",   6'h3F,    32'h1,         32'h1,          5'd0,  32'h0,         1'b0});

        mds.push_back('{"mult_neg",    alu_mult,  32'hFFFF_FFFE, 32'h3,         64'hFFFF_FFFF_FFFF_FFFA});
        mds.push_back('{"div_neg",     alu_div,   32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD});
        mds.push_back('{"divu_by0",    alu_divu,  32'h7,         32'h0,         64'h0000_0007_FFFF_FFFF});
        mds.push_back('{"div_min_m1",  alu_div,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
        mds.push_back('{"multu_max",   alu_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        mds.push_back('{"divu_100_7",  alu_divu,  32'd100,       32'd7,         64'h0000_0002_0000_000E});
        mds.push_back('{"div_7_m2",    alu_div,   32'h7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
        mds.push_back('{"div_m8_by0",  alu_div,   32'hFFFF_FFF8, 32'h0,         64'hFFFF_FFF8_FFFF_FFFF});

        rst       = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
        bus.shamt = '0;
        bus.op    = alu_add;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
        prev_hi = '0;
        prev_lo = '0;

        foreach (vecs[i]) begin
            bus.op    = vecs[i].op;
            bus.a     = vecs[i].a;
            bus.b     = vecs[i].b;
            bus.shamt = vecs[i].shamt;
            #1;
            check({vecs[i].name, "_y"}, 64'(bus.y), 64'(vecs[i].y));
            check({vecs[i].name, "_zero"}, 64'(bus.zero), 64'(vecs[i].y == 32'h0));
            check({vecs[i].name, "_ovf"}, 64'(bus.overflow), 64'(vecs[i].ovf));
        end
        @(negedge clk);

        foreach (mds[i]) run_md(mds[i].name, mds[i].op, mds[i].a, mds[i].b, mds[i].hilo);

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
                0: rop = alu_mult;
                1: rop = alu_multu;
                2: rop = alu_div;
                default: rop = alu_divu;
            endcase
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            run_md($sformatf("rand%0d_op%0h", i, rop), rop, ra, rb, model(rop, ra, rb));
        end

        // mfhi/mflo read back the last result
        bus.op = alu_mfhi;
        #1 check("mfhi_y", 64'(bus.y), 64'(prev_hi));
        bus.op = alu_mflo;
        #1 check("mflo_y", 64'(bus.y), 64'(prev_lo));

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        issue(alu_mthi, 32'hCAFE_F00D, 32'h0);
        issue(alu_mtlo, 32'h1234_5678, 32'h0);
        @(negedge clk);
        check("mthi_mtlo", {bus.hi, bus.lo}, 64'hCAFE_F00D_1234_5678);
        prev_hi = 32'hCAFE_F00D;
        prev_lo = 32'h1234_5678;

        // Back-to-back: restart from DONE with no idle cycle
        sb_q.push_back('{"b2b_first", model(alu_mult, 32'hFFFF_FFFE, 32'h3)});
        issue(alu_mult, 32'hFFFF_FFFE, 32'h3);
        wait_done(cyc, ok);
        check("b2b_first_done_seen", 64'(ok), 64'd1);
        pop_compare();
        sb_q.push_back('{"b2b_second", 64'h0000_0000_8000_0000});
        issue(alu_div, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        check("b2b_no_idle", {62'h0, bus.busy, bus.done}, 64'h2);
        wait_done(cyc, ok);
        check("b2b_second_done_seen", 64'(ok), 64'd1);
        check("b2b_second_busy_cycles", 64'(cyc), 64'd31);
        pop_compare();
        @(negedge clk);

        // start while busy is ignored
        sb_q.push_back('{"busy_ignore", model(alu_multu, 32'd12345, 32'd678)});
        issue(alu_multu, 32'd12345, 32'd678);
        repeat (3) @(negedge clk);
        bus.op    = alu_mthi;
        bus.a     = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_ignore_hi", 64'(bus.hi), 64'(prev_hi));
        wait_done(cyc, ok);
        check("busy_ignore_done_seen", 64'(ok), 64'd1);
        check("busy_ignore_busy_cycles", 64'(cyc), 64'd28);
        pop_compare();
        @(negedge clk);

        // flush on the 10th busy cycle of a divu
        issue(alu_divu, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = alu_mult;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush_idle", {62'h0, bus.busy, bus.done}, 64'h0);
        check("flush_hilo", {bus.hi, bus.lo}, {prev_hi, prev_lo});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("flush_no_done", 64'(seen), 64'd0);

        // reset mid-multu
        issue(alu_multu, 32'hFFFF, 32'hFFFF);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("rst_mid_no_done", 64'(seen), 64'd0);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
